// File: rtl/clock_domain_import.sv
`default_nettype none
// ============================================================================
// Module      : clock_domain_import
// Description : Receiving side of a two-wire clock-domain-crossing handshake.
//               Requests one word at a time from the exporter, synchronizes
//               the exporter's flag, captures its stable data buffer and
//               presents the word locally with valid/ack flow control.
//               Optional build macro CLOCK_DOMAIN_IMPORT_SYNC3_EN selects a
//               3-flop flag synchronizer (default is 2 flops).
// Revision    : 1.0 - initial release
// ============================================================================
module clock_domain_import #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] handshake_buffer,
    input  logic             handshake_other,
    output logic             handshake_local,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ack
);

`ifdef CLOCK_DOMAIN_IMPORT_SYNC3_EN
    localparam int c_SYNC_STAGES = 3;
`else
    localparam int c_SYNC_STAGES = 2;
`endif

    // Handshake state encoding
    localparam logic [1:0] c_S_WAIT_DOWN  = 2'd0;
    localparam logic [1:0] c_S_WAIT_EMPTY = 2'd1;
    localparam logic [1:0] c_S_REQ        = 2'd2;

    logic [c_SYNC_STAGES-1:0] r_sync;
    logic                     w_other_s;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_local;
    logic             w_local_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;
    logic             r_valid;
    logic             w_valid_nxt;

    // Flag synchronizer; resets high so a stale exporter flag is never
    // mistaken for "already low" right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[c_SYNC_STAGES-2:0], handshake_other};
        end
    end

    assign w_other_s = r_sync[c_SYNC_STAGES-1];

    // State and registered outputs; handshake_local is a flop so the
    // exporter only ever sees clean transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_WAIT_DOWN;
            r_local <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_local <= w_local_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // Next-state and output logic. The buffer is sampled only on the capture
    // edge in c_S_REQ, where the exporter guarantees it is stable.
    always_comb begin
        w_state_nxt = r_state;
        w_local_nxt = r_local;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;

        // Consumer takes the word; ack is ignored while nothing is held.
        if (r_valid && ack) begin
            w_valid_nxt = 1'b0;
        end

        case (r_state)
            c_S_WAIT_DOWN: begin
                w_local_nxt = 1'b0;
                if (!w_other_s) begin
                    w_state_nxt = c_S_WAIT_EMPTY;
                end
            end
            c_S_WAIT_EMPTY: begin
                w_local_nxt = 1'b0;
                if (!r_valid || ack) begin
                    w_local_nxt = 1'b1;
                    w_state_nxt = c_S_REQ;
                end
            end
            c_S_REQ: begin
                w_local_nxt = 1'b1;
                if (w_other_s) begin
                    w_data_nxt  = handshake_buffer;
                    w_valid_nxt = 1'b1;
                    w_local_nxt = 1'b0;
                    w_state_nxt = c_S_WAIT_DOWN;
                end
            end
            default: begin
                w_local_nxt = 1'b0;
                w_state_nxt = c_S_WAIT_DOWN;
            end
        endcase
    end

    assign handshake_local = r_local;
    assign data            = r_data;
    assign valid           = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_clock_domain_import.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_domain_import
// Description : Self-checking bench for clock_domain_import. Plays the
//               exporter side of the handshake, runs a table of transfers
//               with varying consumer backpressure, and covers reset timing,
//               buffer isolation and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_domain_import;

`ifdef CLOCK_DOMAIN_IMPORT_SYNC3_EN
    localparam int c_N = 3;
`else
    localparam int c_N = 2;
`endif
    localparam int c_WIDTH = 8;

    logic               clk;
    logic               rst_n;
    logic [c_WIDTH-1:0] handshake_buffer;
    logic               handshake_other;
    logic               handshake_local;
    logic [c_WIDTH-1:0] data;
    logic               valid;
    logic               ack;

    int errors = 0;
    int checks = 0;

    logic [c_WIDTH-1:0] r_expq[$];

    typedef struct {
        logic [c_WIDTH-1:0] buf_val;
        int                 ack_delay;
        logic [c_WIDTH-1:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    clock_domain_import #(.WIDTH(c_WIDTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .handshake_buffer (handshake_buffer),
        .handshake_other  (handshake_other),
        .handshake_local  (handshake_local),
        .data             (data),
        .valid            (valid),
        .ack              (ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_local_high();
        int n;
        n = 0;
        while (handshake_local !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("request_timeout", {31'd0, handshake_local}, 32'd1);
    endtask

    // One exporter transfer followed by consumer ack after ack_delay cycles.
    task automatic run_transfer(input vec_t v);
        logic [c_WIDTH-1:0] exp_word;
        int                 rise;
        wait_local_high();
        handshake_buffer = v.buf_val;
        handshake_other  = 1'b1;
        r_expq.push_back(v.exp_data);
        for (int i = 1; i <= c_N; i++) begin
            tick();
            check("no_early_capture", {31'd0, valid}, 32'd0);
            check("req_held", {31'd0, handshake_local}, 32'd1);
        end
        tick();
        exp_word = (r_expq.size() > 0) ? r_expq.pop_front() : 'x;
        check("capture_data", {24'd0, data}, {24'd0, exp_word});
        check("capture_valid", {31'd0, valid}, 32'd1);
        check("capture_local", {31'd0, handshake_local}, 32'd0);
        // Exporter withdraws its flag; buffer is scrambled to prove isolation.
        handshake_other  = 1'b0;
        handshake_buffer = 8'hFF ^ v.buf_val ^ 8'h11;
        rise = (v.ack_delay > c_N + 1) ? v.ack_delay : c_N + 1;
        for (int e = 0; e <= rise; e++) begin
            ack = (e == v.ack_delay);
            tick();
            check("hold_data", {24'd0, data}, {24'd0, exp_word});
            check("valid_clear", {31'd0, valid}, (e < v.ack_delay) ? 32'd1 : 32'd0);
            check("rerequest", {31'd0, handshake_local}, (e >= rise) ? 32'd1 : 32'd0);
        end
        ack = 1'b0;
    endtask

    initial begin
        vecs[0] = '{buf_val: 8'hA5, ack_delay: 1,  exp_data: 8'hA5};
        vecs[1] = '{buf_val: 8'hFF, ack_delay: 0,  exp_data: 8'hFF};
        vecs[2] = '{buf_val: 8'h3C, ack_delay: 20, exp_data: 8'h3C};
        vecs[3] = '{buf_val: 8'h5A, ack_delay: 3,  exp_data: 8'h5A};
        vecs[4] = '{buf_val: 8'h00, ack_delay: 2,  exp_data: 8'h00};

        rst_n            = 1'b0;
        handshake_other  = 1'b0;
        handshake_buffer = '0;
        ack              = 1'b0;
        tick();
        tick();
        check("rst_local", {31'd0, handshake_local}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_data", {24'd0, data}, 32'd0);

        // First request lands on edge N+2 after reset release.
        rst_n = 1'b1;
        for (int e = 1; e <= c_N + 1; e++) begin
            tick();
            check("pre_req_local", {31'd0, handshake_local}, 32'd0);
            check("pre_req_valid", {31'd0, valid}, 32'd0);
            check("pre_req_data", {24'd0, data}, 32'd0);
        end
        tick();
        check("first_req", {31'd0, handshake_local}, 32'd1);

        for (int i = 0; i < 5; i++) begin
            run_transfer(vecs[i]);
        end

        // Async reset with a captured word pending.
        wait_local_high();
        handshake_buffer = 8'hA5;
        handshake_other  = 1'b1;
        for (int i = 0; i <= c_N; i++) tick();
        check("ar_pre_valid", {31'd0, valid}, 32'd1);
        check("ar_pre_local", {31'd0, handshake_local}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_data", {24'd0, data}, 32'd0);
        check("ar_valid", {31'd0, valid}, 32'd0);
        check("ar_local", {31'd0, handshake_local}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("ar_no_req", {31'd0, handshake_local}, 32'd0);
        end
        handshake_other = 1'b0;
        for (int i = 1; i <= c_N + 2; i++) begin
            tick();
            check("ar_req_after_fall", {31'd0, handshake_local}, (i == c_N + 2) ? 32'd1 : 32'd0);
        end
        check("scoreboard_empty", r_expq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
